gf2m8_arith_unit: RTL and testbench



---
 rtl/gf2m8_pkg.sv | 44 ++++
 rtl/gf2m8_icg_cell.sv | 29 ++
 rtl/gf2m8_arith_unit.sv | 78 +++++++
 tb/tb_gf2m8_arith_unit.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf2m8_pkg.sv
// Shared GF(2^8) definitions: field width, reduction polynomial (0x11D),
// operation encodings and the field multiply/inverse helpers used by the
// arithmetic unit.
package gf2m8_pkg;

   localparam int unsigned GF_W = 8;
   // Low byte of x^8+x^4+x^3+x^2+1; the x^8 term is implied by the shift-out.
   localparam logic [GF_W-1:0] GF_POLY = 8'h1D;

   typedef enum logic [1:0] {
      OP_MUL = 2'b00,
      OP_INV = 2'b01,
      OP_DIV = 2'b10,
      OP_ADD = 2'b11
   } op_sel_e;

   // Shift-and-add multiply with reduction folded into each doubling step.
   function automatic logic [GF_W-1:0] gf_mul(input logic [GF_W-1:0] a,
                                               input logic [GF_W-1:0] b);
      logic [GF_W-1:0] acc;
      logic [GF_W-1:0] sh;
      acc = '0;
      sh  = a;
      for (int i = 0; i < int'(GF_W); i++) begin
         if (b[i]) acc = acc ^ sh;
         sh = sh[GF_W-1] ? ({sh[GF_W-2:0], 1'b0} ^ GF_POLY) : {sh[GF_W-2:0], 1'b0};
      end
      return acc;
   endfunction

   // x^254 = x^2 * x^4 * ... * x^128; zero maps to zero naturally.
   function automatic logic [GF_W-1:0] gf_inv(input logic [GF_W-1:0] a);
      logic [GF_W-1:0] acc;
      logic [GF_W-1:0] sq;
      acc = 8'h01;
      sq  = a;
      for (int i = 1; i < int'(GF_W); i++) begin
         sq  = gf_mul(sq, sq);
         acc = gf_mul(acc, sq);
      end
      return acc;
   endfunction

endpackage

// File: rtl/gf2m8_icg_cell.sv
// Integrated clock gate: negative-level enable latch followed by an AND.
// Only built when GF2M8_ICG_EN is defined; otherwise the unit needs no gate.
//   clk  in  free-running clock
//   ena  in  gate enable, captured while clk is low
//   rstn in  async active-low reset, clears the enable latch
//   gclk out gated clock (clk & latched ena)
`ifdef GF2M8_ICG_EN
module gf2m8_icg_cell (
   input  logic clk,
   input  logic ena,
   input  logic rstn,
   output logic gclk
);

   logic en_lat;

   // Transparent while clk is low so the enable is stable across the high phase.
   always_latch begin
      if (!rstn) begin
         en_lat = 1'b0;
      end else if (!clk) begin
         en_lat = ena;
      end
   end

   assign gclk = clk & en_lat;

endmodule
`endif

// File: rtl/gf2m8_arith_unit.sv
// Registered GF(2^8) arithmetic unit (poly 0x11D): MUL, INV, DIV, ADD with
// one-cycle latency and throughput of one operation per cycle.
//   clk     in   system clock
//   rstn    in   async active-low reset
//   op_ena  in   operation request
//   op_sel  in   [1:0] 00 MUL, 01 INV, 10 DIV, 11 ADD
//   op_x    in   [7:0] operand x
//   op_y    in   [7:0] operand y (unused for INV)
//   res_z   out  [7:0] registered result, holds between operations
//   res_vld out  one-cycle pulse per accepted operation
// Build option GF2M8_ICG_EN: result register clocked through gf2m8_icg_cell
// instead of a load-enabled flop on clk; cycle behaviour is identical.
module gf2m8_arith_unit
   import gf2m8_pkg::*;
(
   input  logic            clk,
   input  logic            rstn,
   input  logic            op_ena,
   input  logic [1:0]      op_sel,
   input  logic [GF_W-1:0] op_x,
   input  logic [GF_W-1:0] op_y,
   output logic [GF_W-1:0] res_z,
   output logic            res_vld
);

   logic [GF_W-1:0] result_c;

   // Combinational field datapath; DIV by zero falls out as zero since inv(0)=0.
   always_comb begin
      result_c = '0;
      case (op_sel_e'(op_sel))
         OP_MUL:  result_c = gf_mul(op_x, op_y);
         OP_INV:  result_c = gf_inv(op_x);
         OP_DIV:  result_c = gf_mul(op_x, gf_inv(op_y));
         OP_ADD:  result_c = op_x ^ op_y;
         default: result_c = '0;
      endcase
   end

   // Valid pulse on the free-running clock.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_vld <= 1'b0;
      end else begin
         res_vld <= op_ena;
      end
   end

`ifdef GF2M8_ICG_EN
   logic gclk;

   gf2m8_icg_cell u_icg (
      .clk  (clk),
      .ena  (op_ena),
      .rstn (rstn),
      .gclk (gclk)
   );

   // Result register only sees edges on accepted operations.
   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         res_z <= '0;
      end else begin
         res_z <= result_c;
      end
   end
`else
   // Result register with load enable; idle cycles never sample op_sel.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         res_z <= '0;
      end else if (op_ena) begin
         res_z <= result_c;
      end
   end
`endif

endmodule

// File: tb/tb_gf2m8_arith_unit.sv
// Self-checking bench for gf2m8_arith_unit. Expected results come from a
// log/antilog model of GF(2^8) built here and from fixed reference values.
module tb_gf2m8_arith_unit;

   logic       clk;
   logic       rstn;
   logic       op_ena;
   logic [1:0] op_sel;
   logic [7:0] op_x;
   logic [7:0] op_y;
   logic [7:0] res_z;
   logic       res_vld;

   int total = 0;
   int bad   = 0;

   logic [7:0] sb[$];
   logic [7:0] exp_t[0:254];
   int         log_t[0:255];
   int         gclk_edges = 0;

   gf2m8_arith_unit dut (
      .clk     (clk),
      .rstn    (rstn),
      .op_ena  (op_ena),
      .op_sel  (op_sel),
      .op_x    (op_x),
      .op_y    (op_y),
      .res_z   (res_z),
      .res_vld (res_vld)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef GF2M8_ICG_EN
   always @(posedge dut.gclk) gclk_edges++;
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   // Antilog table by repeated multiplication by alpha = 0x02.
   task automatic init_tables();
      logic [8:0] v;
      v = 9'h001;
      for (int i = 0; i < 256; i++) log_t[i] = 0;
      for (int i = 0; i < 255; i++) begin
         exp_t[i]          = v[7:0];
         log_t[int'(v[7:0])] = i;
         v = {v[7:0], 1'b0};
         if (v[8]) v = v ^ 9'h11D;
      end
   endtask

   function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
      if (a == 8'h00 || b == 8'h00) return 8'h00;
      return exp_t[(log_t[int'(a)] + log_t[int'(b)]) % 255];
   endfunction

   function automatic logic [7:0] m_inv(input logic [7:0] a);
      if (a == 8'h00) return 8'h00;
      return exp_t[(255 - log_t[int'(a)]) % 255];
   endfunction

   function automatic logic [7:0] m_op(input logic [1:0] s, input logic [7:0] a,
                                       input logic [7:0] b);
      case (s)
         2'b00:   return m_mul(a, b);
         2'b01:   return m_inv(a);
         2'b10:   return m_mul(a, m_inv(b));
         default: return a ^ b;
      endcase
   endfunction

   // Drive one operation on the falling edge and record its expected result.
   task automatic drive_op(input logic [1:0] s, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] expv);
      @(negedge clk);
      op_ena = 1'b1;
      op_sel = s;
      op_x   = a;
      op_y   = b;
      sb.push_back(expv);
   endtask

   task automatic drive_idle();
      @(negedge clk);
      op_ena = 1'b0;
      op_sel = 2'bxx;
      op_x   = $urandom_range(0, 255);
      op_y   = $urandom_range(0, 255);
   endtask

   task automatic test_reset();
      rstn   = 1'b0;
      op_ena = 1'b0;
      op_sel = 2'b00;
      op_x   = 8'h00;
      op_y   = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (res_z !== 8'h00 || res_vld !== 1'b0) begin
         bad++;
         $display("FAIL reset: res_z=%h res_vld=%b want 00/0", res_z, res_vld);
      end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_mul();
      logic [7:0] tx[3] = '{8'h02, 8'h03, 8'h00};
      logic [7:0] ty[3] = '{8'h80, 8'h03, 8'hFF};
      logic [7:0] tz[3] = '{8'h1D, 8'h05, 8'h00};
      logic [7:0] e;
      for (int i = 0; i < 3; i++) begin
         drive_op(2'b00, tx[i], ty[i], tz[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL mul %h*%h: res_z=%h vld=%b want %h/1", tx[i], ty[i], res_z, res_vld, e);
         end
         drive_idle();
         @(posedge clk);
         #1;
         total++;
         if (res_vld !== 1'b0 || res_z !== e) begin
            bad++;
            $display("FAIL mul_pulse: res_z=%h vld=%b want %h/0", res_z, res_vld, e);
         end
      end
   endtask

   task automatic test_inv();
      logic [7:0] tx[3] = '{8'h02, 8'h01, 8'h00};
      logic [7:0] tz[3] = '{8'h8E, 8'h01, 8'h00};
      logic [7:0] e;
      for (int i = 0; i < 3; i++) begin
         drive_op(2'b01, tx[i], 8'hA7, tz[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL inv %h: res_z=%h vld=%b want %h/1", tx[i], res_z, res_vld, e);
         end
      end
      drive_idle();
   endtask

   // Every nonzero x: INV against the model, then x*inv(x) must be 1.
   task automatic test_inv_sweep();
      logic [7:0] e;
      for (int x = 1; x < 256; x++) begin
         drive_op(2'b01, 8'(x), 8'h00, m_inv(8'(x)));
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL inv_sweep %h: res_z=%h want %h", 8'(x), res_z, e);
         end
         drive_op(2'b00, 8'(x), m_inv(8'(x)), 8'h01);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL inv_product %h: res_z=%h want %h", 8'(x), res_z, e);
         end
      end
      drive_idle();
   endtask

   task automatic test_div_add();
      logic [1:0] ts[3] = '{2'b10, 2'b10, 2'b11};
      logic [7:0] tx[3] = '{8'h1D, 8'h55, 8'hA5};
      logic [7:0] ty[3] = '{8'h02, 8'h00, 8'h5A};
      logic [7:0] tz[3] = '{8'h80, 8'h00, 8'hFF};
      logic [7:0] e;
      for (int i = 0; i < 3; i++) begin
         drive_op(ts[i], tx[i], ty[i], tz[i]);
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL div_add sel=%0d %h,%h: res_z=%h vld=%b want %h/1",
                     ts[i], tx[i], ty[i], res_z, res_vld, e);
         end
      end
      drive_idle();
   endtask

   task automatic test_hold();
      logic [7:0] e;
      int         edges0;
      drive_op(2'b00, 8'h02, 8'h80, 8'h1D);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (res_vld !== 1'b1 || res_z !== e) begin
         bad++;
         $display("FAIL hold_op: res_z=%h vld=%b want %h/1", res_z, res_vld, e);
      end
      edges0 = gclk_edges;
      for (int i = 0; i < 5; i++) begin
         drive_idle();
         @(posedge clk);
         #1;
         total++;
         if (res_vld !== 1'b0 || res_z !== 8'h1D) begin
            bad++;
            $display("FAIL hold cycle %0d: res_z=%h vld=%b want 1d/0", i, res_z, res_vld);
         end
      end
`ifdef GF2M8_ICG_EN
      total++;
      if (gclk_edges !== edges0) begin
         bad++;
         $display("FAIL hold_gclk: edges=%0d want 0", gclk_edges - edges0);
      end
`endif
   endtask

   task automatic test_back_to_back();
      logic [1:0] s;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] e;
      for (int i = 0; i < 40; i++) begin
         s = 2'($urandom_range(0, 3));
         a = 8'($urandom_range(0, 255));
         b = (i % 8 == 0) ? 8'h00 : 8'($urandom_range(0, 255));
         drive_op(s, a, b, m_op(s, a, b));
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL b2b sel=%0d %h,%h: res_z=%h vld=%b want %h/1", s, a, b, res_z, res_vld, e);
         end
      end
      drive_idle();
   endtask

   task automatic test_reset_mid();
      logic [7:0] e;
      logic [7:0] tx[4] = '{8'h57, 8'h83, 8'hC3, 8'h10};
      logic [7:0] ty[4] = '{8'h13, 8'h1B, 8'h09, 8'hEE};
      for (int i = 0; i < 4; i++) begin
         drive_op(2'b00, tx[i], ty[i], m_mul(tx[i], ty[i]));
         @(posedge clk);
         #1;
         e = sb.pop_front();
         total++;
         if (res_vld !== 1'b1 || res_z !== e) begin
            bad++;
            $display("FAIL rst_mid op %0d: res_z=%h vld=%b want %h/1", i, res_z, res_vld, e);
         end
      end
      #2;
      rstn = 1'b0;
      #1;
      total++;
      if (res_z !== 8'h00 || res_vld !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid async: res_z=%h vld=%b want 00/0", res_z, res_vld);
      end
      drive_idle();
      @(posedge clk);
      #1;
      total++;
      if (res_z !== 8'h00 || res_vld !== 1'b0) begin
         bad++;
         $display("FAIL rst_mid held: res_z=%h vld=%b want 00/0", res_z, res_vld);
      end
      @(negedge clk);
      rstn = 1'b1;
      drive_op(2'b10, 8'h1D, 8'h02, 8'h80);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      total++;
      if (res_vld !== 1'b1 || res_z !== e) begin
         bad++;
         $display("FAIL rst_mid after: res_z=%h vld=%b want %h/1", res_z, res_vld, e);
      end
      drive_idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      init_tables();
      test_reset();
      test_mul();
      test_inv();
      test_div_add();
      test_hold();
      test_inv_sweep();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
